// File: rtl/serial_addsub_pkg.sv
// Shared encodings for the bit-serial adder/subtractor.
package serial_addsub_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/full_adder.sv
// 1-bit full adder cell used as the serial bit-slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one operand bit per clock through a single full_adder,
// LSB first, with a registered carry and a start/busy/done handshake.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fa_s, fa_cout;

    full_adder u_fa (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .cin  (c_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        acc_d    = acc_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B here, seed the carry with 1.
                    sa_d    = a;
                    sb_d    = b ^ {WIDTH{sub}};
                    c_d     = (sub == OP_SUB);
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                acc_d = {fa_s, acc_q[WIDTH-1:1]};
                c_d   = fa_cout;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // c_q is the carry into the MSB, fa_cout the carry out of it.
                    result_d = acc_d;
                    cout_d   = fa_cout;
                    ovf_d    = c_q ^ fa_cout;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            acc_q    <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            acc_q    <= acc_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed and randomized checks of serial_addsub at WIDTH=8.
module tb_serial_addsub;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, overflow;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Start an op; returns at the negedge where done is first seen high.
    // lat counts cycles from the cycle start was asserted (0) to the done cycle.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                         output int lat);
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; sub = isub;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL op_timeout a=%0d b=%0d sub=%0d: done never seen within %0d cycles", ia, ib, isub, lat);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, cout, overflow} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got busy/done/cout/ovf=%b expected 0000", {busy, done, cout, overflow});
        end
        checks++;
        if (result !== 8'h00) begin
            errors++;
            $display("FAIL reset_result got %h expected 00", result);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add_sub();
        logic [W-1:0] ta [6];
        logic [W-1:0] tb [6];
        logic         ts [6];
        logic [W-1:0] er [6];
        logic         ec [6];
        logic         eo [6];
        int lat;
        ta = '{8'd100, 8'd200, 8'd127, 8'd5,  8'h80, 8'd9};
        tb = '{8'd27,  8'd100, 8'd1,   8'd7,  8'd1,  8'd9};
        ts = '{1'b0,   1'b0,   1'b0,   1'b1,  1'b1,  1'b1};
        er = '{8'h7F,  8'h2C,  8'h80,  8'hFE, 8'h7F, 8'h00};
        ec = '{1'b0,   1'b1,   1'b0,   1'b0,  1'b1,  1'b1};
        eo = '{1'b0,   1'b0,   1'b1,   1'b0,  1'b1,  1'b0};
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tb[i], ts[i], lat);
            checks++;
            if (lat !== 9) begin
                errors++;
                $display("FAIL latency_%0d got %0d cycles expected 9", i, lat);
            end
            checks++;
            if ({result, cout, overflow} !== {er[i], ec[i], eo[i]}) begin
                errors++;
                $display("FAIL op_%0d got result=%h cout=%b ovf=%b expected result=%h cout=%b ovf=%b",
                         i, result, cout, overflow, er[i], ec[i], eo[i]);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse_%0d got done=%b busy=%b after done cycle expected 0 0", i, done, busy);
            end
            checks++;
            if (result !== er[i]) begin
                errors++;
                $display("FAIL result_hold_%0d got %h expected %h", i, result, er[i]);
            end
        end
    endtask

    task automatic test_start_during_run();
        int lat;
        @(negedge clk);
        start = 1'b1; a = 8'd10; b = 8'd20; sub = 1'b0;
        @(negedge clk);
        a = 8'd99; b = 8'd1; sub = 1'b1;
        lat = 1;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
            checks++;
            if (lat < 9 && busy !== 1'b1) begin
                errors++;
                $display("FAIL run_busy cycle %0d got busy=%b expected 1", lat, busy);
            end
            if (lat >= 7) start = 1'b0;
        end
        checks++;
        if (lat !== 9 || {result, cout, overflow} !== {8'd30, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL start_in_run got lat=%0d result=%h cout=%b ovf=%b expected lat=9 result=1e 0 0",
                     lat, result, cout, overflow);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_op(8'd50, 8'd60, 1'b0, lat);
        checks++;
        if (result !== 8'd110) begin
            errors++;
            $display("FAIL b2b_first got %h expected 6e", result);
        end
        // Still in the DONE cycle: launch the next op immediately.
        start = 1'b1; a = 8'd3; b = 8'd4; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_busy got %b expected 1", busy);
        end
        lat = 1;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 9 || result !== 8'd7) begin
            errors++;
            $display("FAIL b2b_second got lat=%0d result=%h expected lat=9 result=07", lat, result);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        @(negedge clk);
        start = 1'b1; a = 8'd1; b = 8'd2; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00 || result !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_run got busy=%b done=%b result=%h expected 0 0 00", busy, done, result);
        end
        do_op(8'd1, 8'd1, 1'b0, lat);
        checks++;
        if (lat !== 9 || result !== 8'd2) begin
            errors++;
            $display("FAIL after_reset got lat=%0d result=%h expected lat=9 result=02", lat, result);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [W-1:0] ra, rb, er;
        logic         rs, ec, eo;
        logic [W:0]   sum;
        for (int i = 0; i < 500; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            sum = {1'b0, ra} + (rs ? ({1'b0, ~rb} + 9'd1) : {1'b0, rb});
            er  = sum[W-1:0];
            ec  = sum[W];
            eo  = rs ? ((ra[W-1] != rb[W-1]) && (er[W-1] != ra[W-1]))
                     : ((ra[W-1] == rb[W-1]) && (er[W-1] != ra[W-1]));
            do_op(ra, rb, rs, lat);
            checks++;
            if ({result, cout, overflow} !== {er, ec, eo}) begin
                errors++;
                $display("FAIL rand_%0d a=%h b=%h sub=%b got %h/%b/%b expected %h/%b/%b",
                         i, ra, rb, rs, result, cout, overflow, er, ec, eo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
